// File: rtl/led_mode_sched_if.sv
// Signal bundle between the mode scheduler and its users: the host command port,
// the debounced key, the auto-rotate enable and the pattern-FSM drive outputs.
// Handshake: a host request transfers on a rising clk edge where cmd_valid && cmd_ready.
// cmd_valid and cmd_mode must be held until then. key_valid is a one-cycle pulse with no
// back-pressure.
interface led_mode_sched_if;
  logic       cmd_valid;
  logic [1:0] cmd_mode;
  logic       cmd_ready;
  logic       key_valid;
  logic [1:0] key_mode;
  logic       auto_en;
  logic [1:0] mode;
  logic       tick;
  logic       restart;
  logic       blank;
  logic [1:0] grant;
  logic       state_out;

  // Requester / observer side.
  modport master (
    output cmd_valid, cmd_mode, key_valid, key_mode, auto_en,
    input  cmd_ready, mode, tick, restart, blank, grant, state_out
  );

  // Scheduler side.
  modport slave (
    input  cmd_valid, cmd_mode, key_valid, key_mode, auto_en,
    output cmd_ready, mode, tick, restart, blank, grant, state_out
  );
endinterface

// File: rtl/led_mode_sched.sv
// Mode scheduler for the 4-LED pattern FSM. Arbitrates host, key and auto-rotate
// mode requests (host > key > auto). Every real mode change restarts the pattern
// after a BLANK_TICKS-step LEDs-off gap.
// Optional feature: define LED_SCHED_AUTO_EN to build the dwell counter and the
// auto-rotate request. Without it, auto_en is ignored.
module led_mode_sched #(
  parameter int unsigned TICK_DIV    = 12500000,
  parameter int unsigned BLANK_TICKS = 2,
  parameter int unsigned DWELL_TICKS = 16,
  parameter logic [1:0]  INIT_MODE   = 2'b00
) (
  input logic             clk,
  input logic             rst,
  led_mode_sched_if.slave sif
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_TICKS - 1);

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_HOST = 2'b01;
  localparam logic [1:0] GNT_KEY  = 2'b10;
  localparam logic [1:0] GNT_AUTO = 2'b11;

  typedef enum logic {S_RUN = 1'b0, S_BLANK = 1'b1} state_t;

  state_t        state_q;
  logic [1:0]    mode_q;
  logic          restart_q;
  logic          blank_q;
  logic [1:0]    grant_q;
  logic [TW-1:0] tcnt_q;
  logic [BW-1:0] bcnt_q;
  logic          pend_q;
  logic [1:0]    pmode_q;

  logic       is_run;
  logic       strobe;
  logic       tick_w;
  logic       key_req;
  logic [1:0] key_tgt;
  logic       auto_due;
  logic       take_host;
  logic       take_key;
  logic       take_auto;
  logic       accept;
  logic       do_switch;
  logic [1:0] req_src;
  logic [1:0] req_mode;

  assign is_run  = (state_q == S_RUN);
  assign strobe  = (tcnt_q == TICK_LAST);
  assign tick_w  = strobe & is_run & ~restart_q;
  // A fresh key pulse overrides a buffered one (last wins).
  assign key_req = sif.key_valid | pend_q;
  assign key_tgt = sif.key_valid ? sif.key_mode : pmode_q;

  assign take_host = is_run & sif.cmd_valid;
  assign take_key  = is_run & ~sif.cmd_valid & key_req;
  assign take_auto = is_run & ~sif.cmd_valid & ~key_req & auto_due;
  assign accept    = take_host | take_key | take_auto;
  assign do_switch = accept & (req_mode != mode_q);

  // Winner's source code and target mode.
  always_comb begin
    req_src  = GNT_NONE;
    req_mode = mode_q;
    if (take_host) begin
      req_src  = GNT_HOST;
      req_mode = sif.cmd_mode;
    end else if (take_key) begin
      req_src  = GNT_KEY;
      req_mode = key_tgt;
    end else if (take_auto) begin
      req_src  = GNT_AUTO;
      req_mode = mode_q + 2'd1;
    end
  end

`ifdef LED_SCHED_AUTO_EN
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
  logic [DW-1:0] dwell_q;

  // An auto request that loses arbitration is simply dropped.
  assign auto_due = sif.auto_en & tick_w & (dwell_q == DWELL_LAST);

  // Dwell counter: RUN ticks since the last accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
    end else if (accept) begin
      dwell_q <= '0;
    end else if (tick_w) begin
      dwell_q <= (dwell_q == DWELL_LAST) ? '0 : dwell_q + DW'(1);
    end
  end
`else
  localparam int unsigned unused_dwell_ticks = DWELL_TICKS;
  logic unused_auto_en;
  assign unused_auto_en = sif.auto_en;
  assign auto_due       = 1'b0;
`endif

  // RUN/BLANK state machine with step counter, key buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      mode_q    <= INIT_MODE;
      restart_q <= 1'b0;
      blank_q   <= 1'b0;
      grant_q   <= GNT_NONE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      pend_q    <= 1'b0;
      pmode_q   <= 2'b00;
    end else begin
      restart_q <= 1'b0;
      tcnt_q    <= strobe ? '0 : tcnt_q + TW'(1);
      // Consumed key clears the buffer; an unserved pulse is latched.
      if (take_key) begin
        pend_q <= 1'b0;
      end else if (sif.key_valid) begin
        pend_q  <= 1'b1;
        pmode_q <= sif.key_mode;
      end
      case (state_q)
        S_RUN: begin
          if (do_switch) begin
            state_q   <= S_BLANK;
            mode_q    <= req_mode;
            grant_q   <= req_src;
            restart_q <= 1'b1;
            blank_q   <= 1'b1;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
          end
        end
        S_BLANK: begin
          if (strobe) begin
            if (bcnt_q == BLANK_LAST) begin
              state_q <= S_RUN;
              blank_q <= 1'b0;
              bcnt_q  <= '0;
            end else begin
              bcnt_q <= bcnt_q + BW'(1);
            end
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign sif.cmd_ready = is_run;
  assign sif.mode      = mode_q;
  assign sif.tick      = tick_w;
  assign sif.restart   = restart_q;
  assign sif.blank     = blank_q;
  assign sif.grant     = grant_q;
  assign sif.state_out = (state_q == S_BLANK);
endmodule

// File: tb/tb_led_mode_sched.sv
// Bench for led_mode_sched with TICK_DIV=4, BLANK_TICKS=2, DWELL_TICKS=3.
// Each switch ({grant, mode}) is queued when its stimulus is driven and checked by
// the restart monitor. Scenario tasks check timing and levels inline.
module tb_led_mode_sched;
  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned BLANK_TICKS = 2;
  localparam int unsigned DWELL_TICKS = 3;
  localparam logic [1:0]  INIT_MODE   = 2'b00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_q[$];

  led_mode_sched_if sif();

  led_mode_sched #(
    .TICK_DIV   (TICK_DIV),
    .BLANK_TICKS(BLANK_TICKS),
    .DWELL_TICKS(DWELL_TICKS),
    .INIT_MODE  (INIT_MODE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif)
  );

  // Clock.
  always #5 clk = ~clk;

  // Scoreboard: each restart pulse must match the next queued {grant, mode}.
  always @(negedge clk) begin
    if (rst === 1'b0 && sif.restart === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL switch_unexpected got grant=%b mode=%b expected none", sif.grant, sif.mode);
      end else begin
        logic [3:0] exp_v;
        exp_v = exp_q.pop_front();
        if ({sif.grant, sif.mode} !== exp_v) begin
          errors++;
          $display("FAIL switch got {grant,mode}=%b expected %b", {sif.grant, sif.mode}, exp_v);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    sif.cmd_valid = 1'b0;
    sif.cmd_mode  = 2'b00;
    sif.key_valid = 1'b0;
    sif.key_mode  = 2'b00;
    sif.auto_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_blank_low();
    for (int i = 0; i < 50 && sif.blank === 1'b1; i++) step();
    checks++;
    if (sif.blank !== 1'b0) begin
      errors++;
      $display("FAIL blank_timeout got blank=%b expected 0", sif.blank);
    end
  endtask

  task automatic test_reset();
    int ticks, bad_gap, bad_lvl, last;
    rst = 1'b1;
    clear_inputs();
    step();
    checks++;
    if ({sif.cmd_ready, sif.mode, sif.restart, sif.blank, sif.grant, sif.state_out, sif.tick}
        !== 9'b1_00_0_0_00_0_0) begin
      errors++;
      $display("FAIL reset_values got %b expected 100000000",
               {sif.cmd_ready, sif.mode, sif.restart, sif.blank, sif.grant, sif.state_out, sif.tick});
    end
    rst = 1'b0;
    ticks = 0; bad_gap = 0; bad_lvl = 0; last = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (sif.tick === 1'b1) begin
        if (last < 0 && k != 3) bad_gap++;
        if (last >= 0 && k - last != 4) bad_gap++;
        last = k;
        ticks++;
      end
      if (sif.restart !== 1'b0 || sif.blank !== 1'b0 || sif.mode !== 2'b00) bad_lvl++;
    end
    checks++;
    if (ticks != 5) begin
      errors++;
      $display("FAIL idle_tick_count got %0d expected 5", ticks);
    end
    checks++;
    if (bad_gap != 0) begin
      errors++;
      $display("FAIL idle_tick_spacing got %0d bad gaps expected 0", bad_gap);
    end
    checks++;
    if (bad_lvl != 0) begin
      errors++;
      $display("FAIL idle_levels got %0d bad cycles expected 0", bad_lvl);
    end
  endtask

  task automatic test_host_switch();
    int nb, tb_cnt, rb_cnt, lat;
    do_reset();
    step();
    sif.cmd_valid = 1'b1;
    sif.cmd_mode  = 2'b10;
    checks++;
    if (sif.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL host_ready got %b expected 1", sif.cmd_ready);
    end
    exp_q.push_back({2'b01, 2'b10});
    step();
    sif.cmd_valid = 1'b0;
    checks++;
    if ({sif.mode, sif.restart, sif.blank, sif.state_out, sif.cmd_ready} !== 6'b10_1_1_1_0) begin
      errors++;
      $display("FAIL host_switch got %b expected 101110",
               {sif.mode, sif.restart, sif.blank, sif.state_out, sif.cmd_ready});
    end
    nb = 1; tb_cnt = 0; rb_cnt = 0;
    for (int i = 0; i < 50 && sif.blank === 1'b1; i++) begin
      step();
      if (sif.blank === 1'b1) begin
        nb++;
        if (sif.tick === 1'b1) tb_cnt++;
        if (sif.restart === 1'b1) rb_cnt++;
      end
    end
    checks++;
    if (nb != 8) begin
      errors++;
      $display("FAIL blank_len got %0d expected 8", nb);
    end
    checks++;
    if (tb_cnt != 0 || rb_cnt != 0) begin
      errors++;
      $display("FAIL blank_quiet got ticks=%0d restarts=%0d expected 0 0", tb_cnt, rb_cnt);
    end
    lat = 1;
    while (sif.tick !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL first_tick_latency got %0d expected 4", lat);
    end
  endtask

  task automatic test_priority();
    do_reset();
    step();
    sif.cmd_valid = 1'b1;
    sif.cmd_mode  = 2'b01;
    sif.key_valid = 1'b1;
    sif.key_mode  = 2'b11;
    exp_q.push_back({2'b01, 2'b01});
    exp_q.push_back({2'b10, 2'b11});
    step();
    sif.cmd_valid = 1'b0;
    sif.key_valid = 1'b0;
    checks++;
    if ({sif.grant, sif.mode, sif.blank} !== 5'b01_01_1) begin
      errors++;
      $display("FAIL host_wins got %b expected 01011", {sif.grant, sif.mode, sif.blank});
    end
    wait_blank_low();
    checks++;
    if ({sif.mode, sif.restart} !== 3'b01_0) begin
      errors++;
      $display("FAIL first_run_cycle got %b expected 010", {sif.mode, sif.restart});
    end
    step();
    checks++;
    if ({sif.grant, sif.mode, sif.restart, sif.blank} !== 6'b10_11_1_1) begin
      errors++;
      $display("FAIL pending_key got %b expected 101111",
               {sif.grant, sif.mode, sif.restart, sif.blank});
    end
    wait_blank_low();
  endtask

  task automatic test_same_mode();
    int bad;
    do_reset();
    step();
    sif.key_valid = 1'b1;
    sif.key_mode  = 2'b00;
    step();
    sif.key_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (sif.restart !== 1'b0 || sif.blank !== 1'b0 || sif.mode !== 2'b00) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL key_same_mode got %0d bad cycles expected 0", bad);
    end
    sif.cmd_valid = 1'b1;
    sif.cmd_mode  = 2'b00;
    checks++;
    if (sif.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL host_same_ready got %b expected 1", sif.cmd_ready);
    end
    step();
    sif.cmd_valid = 1'b0;
    checks++;
    if ({sif.mode, sif.restart, sif.blank, sif.grant} !== 6'b00_0_0_00) begin
      errors++;
      $display("FAIL host_same_mode got %b expected 000000",
               {sif.mode, sif.restart, sif.blank, sif.grant});
    end
    sif.key_valid = 1'b1;
    sif.key_mode  = 2'b01;
    exp_q.push_back({2'b10, 2'b01});
    step();
    sif.key_valid = 1'b0;
    wait_blank_low();
    sif.cmd_valid = 1'b1;
    sif.cmd_mode  = 2'b01;
    step();
    sif.cmd_valid = 1'b0;
    checks++;
    if ({sif.grant, sif.mode, sif.restart, sif.blank} !== 6'b10_01_0_0) begin
      errors++;
      $display("FAIL grant_kept got %b expected 100100",
               {sif.grant, sif.mode, sif.restart, sif.blank});
    end
  endtask

`ifdef LED_SCHED_AUTO_EN
  task automatic test_auto();
    int nr, first, last, bad;
    do_reset();
    sif.auto_en = 1'b1;
    exp_q.push_back({2'b11, 2'b01});
    exp_q.push_back({2'b11, 2'b10});
    exp_q.push_back({2'b11, 2'b11});
    exp_q.push_back({2'b11, 2'b00});
    nr = 0; first = 0; last = 0; bad = 0;
    for (int k = 1; k <= 100 && nr < 4; k++) begin
      step();
      if (sif.restart === 1'b1) begin
        if (nr == 0) first = k;
        else if (k - last != 20) bad++;
        last = k;
        nr++;
      end
    end
    sif.auto_en = 1'b0;
    checks++;
    if (nr != 4 || first != 12) begin
      errors++;
      $display("FAIL auto_first got count=%0d first=%0d expected 4 12", nr, first);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL auto_period got %0d bad intervals expected 0", bad);
    end
    checks++;
    if ({sif.grant, sif.mode} !== 4'b11_00) begin
      errors++;
      $display("FAIL auto_wrap got %b expected 1100", {sif.grant, sif.mode});
    end
  endtask
`else
  task automatic test_auto();
    int bad;
    do_reset();
    sif.auto_en = 1'b1;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (sif.restart !== 1'b0 || sif.mode !== 2'b00 || sif.grant === 2'b11) bad++;
    end
    sif.auto_en = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL auto_disabled got %0d bad cycles expected 0", bad);
    end
  endtask
`endif

  task automatic test_reset_in_blank();
    int bad;
    do_reset();
    step();
    sif.cmd_valid = 1'b1;
    sif.cmd_mode  = 2'b10;
    exp_q.push_back({2'b01, 2'b10});
    step();
    sif.cmd_valid = 1'b0;
    step();
    sif.key_valid = 1'b1;
    sif.key_mode  = 2'b11;
    step();
    sif.key_valid = 1'b0;
    step();
    checks++;
    if (sif.blank !== 1'b1) begin
      errors++;
      $display("FAIL mid_blank got blank=%b expected 1", sif.blank);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({sif.blank, sif.mode, sif.cmd_ready, sif.grant, sif.state_out} !== 7'b0_00_1_00_0) begin
      errors++;
      $display("FAIL async_reset got %b expected 0001000",
               {sif.blank, sif.mode, sif.cmd_ready, sif.grant, sif.state_out});
    end
    step();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (sif.restart !== 1'b0 || sif.mode !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pending_lost got %0d bad cycles expected 0", bad);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_host_switch();
    test_priority();
    test_same_mode();
    test_auto();
    test_reset_in_blank();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
